// File: rtl/fp_mul_issue.sv
// Issue/retire stage for a combinational single-precision multiplier: an operand FIFO feeds
// the multiplier from its head, and each product is captured with its tag and class flags.
module fp_mul_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    input  logic [31:0]                mul_p,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_p,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_t;

    out_state_t state_reg, state_next;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0]      mem_a   [DEPTH];
    logic [31:0]      mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [31:0]      out_p_reg;
    logic [TAG_W-1:0] out_tag_reg;
    logic [3:0]       out_flags_reg;

    logic push;
    logic load;
    logic not_empty;
    logic [3:0] mul_class;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg != CNT_W'(DEPTH));
    assign push      = in_valid & in_ready;

    // Head entry is read asynchronously so the multiplier sees it in the same cycle.
    assign mul_a = not_empty ? mem_a[rd_ptr_reg] : 32'h0;
    assign mul_b = not_empty ? mem_b[rd_ptr_reg] : 32'h0;

    // Storage: one write-enable per entry, no reset needed on the data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_a[gi]   <= in_a;
                    mem_b[gi]   <= in_b;
                    mem_tag[gi] <= in_tag;
                end
            end
        end
    endgenerate

    // Product classification: {nan, inf, zero, subnormal}.
    always_comb begin
        logic exp_all_ones;
        logic exp_zero;
        logic man_zero;
        exp_all_ones = (mul_p[30:23] == 8'hFF);
        exp_zero     = (mul_p[30:23] == 8'h00);
        man_zero     = (mul_p[22:0] == 23'h0);
        mul_class    = {exp_all_ones & ~man_zero,
                        exp_all_ones &  man_zero,
                        exp_zero     &  man_zero,
                        exp_zero     & ~man_zero};
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            OUT_EMPTY: begin
                if (not_empty) begin
                    load       = 1'b1;
                    state_next = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (out_ready) begin
                    if (not_empty) begin
                        load = 1'b1;
                    end else begin
                        state_next = OUT_EMPTY;
                    end
                end
            end
            default: begin
                state_next = OUT_EMPTY;
            end
        endcase
    end

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = load ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, load})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= OUT_EMPTY;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_p_reg     <= 32'h0;
            out_tag_reg   <= '0;
            out_flags_reg <= 4'h0;
        end else if (load) begin
            out_p_reg     <= mul_p;
            out_tag_reg   <= mem_tag[rd_ptr_reg];
            out_flags_reg <= mul_class;
        end
    end

    assign out_valid = (state_reg == OUT_HOLD);
    assign out_p     = out_p_reg;
    assign out_tag   = out_tag_reg;
    assign out_flags = out_flags_reg;
    assign occupancy = count_reg;

endmodule
